// File: rtl/demux_1_16_pkg.sv
// ---------------------------------------------------------------------------
// Module : demux_pkg
// Brief  : Shared constants for the 1-to-16 lane demultiplexer.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package demux_pkg;
  localparam int LANES         = 16;
  localparam int SEL_W         = 4;
  localparam int WIDTH_DEFAULT = 16;
endpackage

`default_nettype wire

// File: rtl/demux_1_16_if.sv
// ---------------------------------------------------------------------------
// Module : demux_1_16_if
// Brief  : Bundle of the demux data-path and handshake signals.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface demux_1_16_if #(
  parameter int WIDTH = demux_pkg::WIDTH_DEFAULT
);
  import demux_pkg::*;

  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       sel;
  logic                   auto_mode;
  logic                   clear;
  logic [LANES-1:0]       out_ack;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] out_bus;
  logic [LANES-1:0]       lane_valid;
  logic [SEL_W-1:0]       ptr;
  logic                   full;

  // Source side: offers words, consumes lanes
  modport master (
    output in_valid, in_data, sel, auto_mode, clear, out_ack,
    input  in_ready, out_bus, lane_valid, ptr, full
  );

  // Demux side
  modport slave (
    input  in_valid, in_data, sel, auto_mode, clear, out_ack,
    output in_ready, out_bus, lane_valid, ptr, full
  );
endinterface

`default_nettype wire

// File: rtl/demux_1_16_dec_4_16.sv
// ---------------------------------------------------------------------------
// Module : dec_4_16
// Brief  : Combinational 4-to-16 one-hot decoder.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dec_4_16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] onehot
);

  // Exactly one bit set, at the position named by sel
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/demux_1_16.sv
// ---------------------------------------------------------------------------
// Module : demux_1_16
// Brief  : 1-to-16 registered demultiplexer with per-lane valid/ack,
//          manual (sel) or round-robin (ptr) lane targeting.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module demux_1_16
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_1_16_if.slave   bus
);

  logic [SEL_W-1:0] w_target;
  logic [LANES-1:0] w_target_oh;
  logic             w_tgt_busy;
  logic             w_tgt_ack;
  logic             w_in_ready;
  logic             w_fire;
  logic [LANES-1:0] w_wr_en;

  logic [WIDTH-1:0] r_data [LANES];
  logic [LANES-1:0] r_valid;
  logic [SEL_W-1:0] r_ptr;

  assign w_target = bus.auto_mode ? r_ptr : bus.sel;

  dec_4_16 u_dec (
    .sel    (w_target),
    .onehot (w_target_oh)
  );

  // A lane accepts a word when empty, or when it is being drained this same
  // cycle; clear blocks acceptance so a flush can never race a write.
  assign w_tgt_busy = |(r_valid & w_target_oh);
  assign w_tgt_ack  = |(bus.out_ack & w_target_oh);
  assign w_in_ready = ~bus.clear & (~w_tgt_busy | w_tgt_ack);
  assign w_fire     = bus.in_valid & w_in_ready;
  assign w_wr_en    = w_fire ? w_target_oh : '0;

  // Per-lane data storage; only a fired write changes a lane's word
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data[k] <= '0;
      end else if (w_wr_en[k]) begin
        r_data[k] <= bus.in_data;
      end
    end
    assign bus.out_bus[k*WIDTH +: WIDTH] = r_data[k];
  end

  // Valid bits: write sets, ack clears, write wins over ack on the same lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (bus.clear) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~bus.out_ack) | w_wr_en;
    end
  end

  // Round-robin pointer advances only on writes made in auto mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (bus.clear) begin
      r_ptr <= '0;
    end else if (w_fire && bus.auto_mode) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.lane_valid = r_valid;
  assign bus.ptr        = r_ptr;
  assign bus.full       = &r_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux_1_16.sv
// ---------------------------------------------------------------------------
// Module : tb_demux_1_16
// Brief  : Directed self-checking bench for demux_1_16.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_demux_1_16;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  demux_1_16_if #(.WIDTH(W)) bus ();

  demux_1_16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_data [16];

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic [15:0] exp_valid;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input int k);
    return bus.out_bus[k*W +: W];
  endfunction

  function automatic logic [255:0] model_bus();
    logic [255:0] b;
    for (int k = 0; k < 16; k++) b[k*W +: W] = m_data[k];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sel       = '0;
    bus.auto_mode = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ack   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int dl [16] = '{1212, 23, 0, 432, 51, 61, 17, 38, 91, 140, 111, 124, 113, 14, 155, 165};
    for (int i = 0; i < 16; i++) begin
      tbl[i].sel       = 4'(i);
      tbl[i].data      = 16'(dl[i]);
      tbl[i].exp_valid = 16'((32'h1 << (i + 1)) - 1);
      m_data[i]        = '0;
    end

    // ---------------- reset state
    idle();
    #12;
    chk("rst_out_bus", 256'(bus.out_bus), 256'd0);
    chk("rst_valid",   256'(bus.lane_valid), 256'd0);
    chk("rst_ptr",     256'(bus.ptr), 256'd0);
    chk("rst_full",    256'(bus.full), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- manual route table
    for (int i = 0; i < 16; i++) begin
      bus.in_valid  = 1'b1;
      bus.auto_mode = 1'b0;
      bus.sel       = tbl[i].sel;
      bus.in_data   = tbl[i].data;
      #1;
      chk($sformatf("man_ready%0d", i), 256'(bus.in_ready), 256'd1);
      tick();
      m_data[tbl[i].sel] = tbl[i].data;
      chk($sformatf("man_lane%0d", i), 256'(lane(int'(tbl[i].sel))), 256'(tbl[i].data));
      chk($sformatf("man_valid%0d", i), 256'(bus.lane_valid), 256'(tbl[i].exp_valid));
    end
    idle();
    #1;
    chk("man_full", 256'(bus.full), 256'd1);
    chk("man_ptr",  256'(bus.ptr), 256'd0);
    chk("man_bus",  256'(bus.out_bus), model_bus());

    // ---------------- backpressure on lane 3
    bus.in_valid = 1'b1;
    bus.sel      = 4'd3;
    bus.in_data  = 16'd7;
    #1;
    chk("bp_ready_blocked", 256'(bus.in_ready), 256'd0);
    tick();
    chk("bp_lane3_held", 256'(lane(3)), 256'd432);
    bus.out_ack = 16'h0008;
    #1;
    chk("bp_ready_ack", 256'(bus.in_ready), 256'd1);
    tick();
    m_data[3] = 16'd7;
    chk("bp_lane3_new", 256'(lane(3)), 256'd7);
    chk("bp_valid", 256'(bus.lane_valid), 256'hFFFF);

    // plain ack without write clears just that lane
    idle();
    bus.out_ack = 16'h0020;
    tick();
    chk("ack_only_valid", 256'(bus.lane_valid), 256'hFFDF);
    chk("ack_only_full",  256'(bus.full), 256'd0);

    // ---------------- clear with write pending, from near-full state
    idle();
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.sel      = 4'd5;
    bus.in_data  = 16'hDEAD;
    tick();
    chk("clr1_valid", 256'(bus.lane_valid), 256'd0);
    chk("clr1_lane5", 256'(lane(5)), 256'd61);

    // ---------------- round robin, 17 writes with trailing acks
    idle();
    for (int i = 0; i < 17; i++) begin
      bus.auto_mode = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'(100 + i);
      bus.out_ack   = (i > 0) ? 16'(32'h1 << ((i - 1) % 16)) : 16'h0;
      #1;
      chk($sformatf("rr_ready%0d", i), 256'(bus.in_ready), 256'd1);
      tick();
      m_data[i % 16] = 16'(100 + i);
      chk($sformatf("rr_lane%0d", i), 256'(lane(i % 16)), 256'(100 + i));
      chk($sformatf("rr_ptr%0d", i), 256'(bus.ptr), 256'((i + 1) % 16));
    end
    idle();
    #1;
    chk("rr_valid_end", 256'(bus.lane_valid), 256'h0001);
    chk("rr_bus", 256'(bus.out_bus), model_bus());

    // ---------------- build lane_valid=FFFF, ptr=9, then clear
    bus.clear = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 9; i++) begin
      bus.auto_mode = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'(200 + i);
      tick();
      m_data[i] = 16'(200 + i);
    end
    for (int k = 9; k < 16; k++) begin
      bus.auto_mode = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 4'(k);
      bus.in_data   = 16'(300 + k);
      tick();
      m_data[k] = 16'(300 + k);
    end
    idle();
    #1;
    chk("pre_clr_ptr",   256'(bus.ptr), 256'd9);
    chk("pre_clr_valid", 256'(bus.lane_valid), 256'hFFFF);
    chk("pre_clr_bus",   256'(bus.out_bus), model_bus());
    bus.clear     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.auto_mode = 1'b1;
    bus.in_data   = 16'd999;
    bus.out_ack   = 16'hFFFF;
    #1;
    chk("clr_ready", 256'(bus.in_ready), 256'd0);
    tick();
    chk("clr_valid", 256'(bus.lane_valid), 256'd0);
    chk("clr_ptr",   256'(bus.ptr), 256'd0);
    chk("clr_bus",   256'(bus.out_bus), model_bus());

    // ---------------- stray ack on empty block
    idle();
    bus.out_ack = 16'hFFFF;
    tick();
    chk("stray_valid", 256'(bus.lane_valid), 256'd0);
    chk("stray_bus",   256'(bus.out_bus), model_bus());

    // ---------------- async reset in mid-write
    idle();
    bus.in_valid  = 1'b1;
    bus.auto_mode = 1'b1;
    bus.in_data   = 16'd55;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) m_data[k] = '0;
    chk("arst_bus",   256'(bus.out_bus), 256'd0);
    chk("arst_valid", 256'(bus.lane_valid), 256'd0);
    chk("arst_ptr",   256'(bus.ptr), 256'd0);
    chk("arst_full",  256'(bus.full), 256'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 256'(bus.lane_valid), 256'd0);
    chk("post_rst_bus",   256'(bus.out_bus), 256'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd77;
    tick();
    chk("post_rst_lane0", 256'(lane(0)), 256'd77);
    chk("post_rst_ptr",   256'(bus.ptr), 256'd1);

    // ---------------- mode toggle: manual write holds ptr, auto resumes at ptr
    bus.auto_mode = 1'b0;
    bus.sel       = 4'd5;
    bus.in_data   = 16'd88;
    tick();
    chk("tog_lane5", 256'(lane(5)), 256'd88);
    chk("tog_ptr",   256'(bus.ptr), 256'd1);
    bus.auto_mode = 1'b1;
    bus.in_data   = 16'd66;
    tick();
    chk("tog_lane1", 256'(lane(1)), 256'd66);
    chk("tog_ptr2",  256'(bus.ptr), 256'd2);
    chk("tog_valid", 256'(bus.lane_valid), 256'h0023);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_1_16.md
DEMUX_1_16 -- requirements
Module: demux_1_16

Interface
REQ-001 Parameter WIDTH, default 16, data width of each lane.
REQ-002 Parameter LANES, fixed 16, number of output lanes; SEL_W = 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_data  input  WIDTH  input word.
REQ-007 sel  input  4  target lane when auto_mode=0.
REQ-008 auto_mode  input  1  1: target lane is internal pointer ptr; 0: target is sel.
REQ-009 clear  input  1  synchronous flush of all lane_valid bits and ptr.
REQ-010 out_ack  input  16  per-lane consume strobe; bit k releases lane k.
REQ-011 in_ready  output  1  write to the current target lane is accepted this cycle.
REQ-012 out_bus  output  16*WIDTH  lane k data at bits [k*WIDTH +: WIDTH].
REQ-013 lane_valid  output  16  lane k holds an unconsumed word.
REQ-014 ptr  output  4  round-robin write pointer.
REQ-015 full  output  1  all 16 lane_valid bits set.

Function
REQ-016 target = auto_mode ? ptr : sel, evaluated combinationally each cycle.
REQ-017 in_ready = ~clear & (~lane_valid[target] | out_ack[target]); combinational, no dependency on in_valid.
REQ-018 Write fires when in_valid & in_ready; on the next edge the target lane data <= in_data and lane_valid[target] <= 1; latency 1 cycle.
REQ-019 Unselected lanes hold data and valid unchanged; data is never cleared except by reset.
REQ-020 Ack on lane k with lane_valid[k]=1 and no write to k clears lane_valid[k] next edge; ack on an empty lane has no effect.
REQ-021 Ack and write to the same lane in the same cycle: lane takes new data, lane_valid stays 1.
REQ-022 ptr increments by 1 on each fired write while auto_mode=1; wraps 15 -> 0; holds otherwise, including during manual-mode writes.
REQ-023 in_valid with in_ready=0 is stalled; no state change; the source holds in_data/sel until accepted.
REQ-024 clear=1: next edge lane_valid <= 0, ptr <= 0; clear overrides any write and ack in the same cycle.
REQ-025 full = &lane_valid, combinational from registered state.
REQ-026 auto_mode toggling mid-stream takes effect the same cycle; ptr is not reset by the toggle.

Reset
REQ-027 On rst_n=0, asynchronously: out_bus=0, lane_valid=0, ptr=0; consequently full=0.
REQ-028 Reset asserted mid-write discards that write; first write after release with auto_mode=1 lands in lane 0.

Structure
REQ-029 Shared package demux_pkg holds LANES=16, SEL_W=4, and default WIDTH=16.
REQ-030 One sub-module dec_4_16: combinational 4-to-16 one-hot decoder producing the lane write enable from target.
REQ-031 Lane storage: 16 WIDTH-bit registers plus the 16-bit valid register; no memories.

Verification
REQ-032 Manual route: auto_mode=0, sel=0..15 in turn, in_data=1212,23,0,432,51,61,17,38,91,140,111,124,113,14,155,165 -> each lane holds its word 1 cycle later, lane_valid=16'hFFFF, full=1, ptr=0.
REQ-033 Backpressure: lane 3 valid, write sel=3 data=7 -> in_ready=0, lane 3 unchanged; same cycle out_ack[3]=1 -> accepted, lane 3=7, lane_valid[3]=1.
REQ-034 Round-robin wrap: auto_mode=1, 17 writes with ack on each lane immediately after fill -> lanes 0..15 filled in order, ptr wraps 15->0, 17th word in lane 0.
REQ-035 Clear priority: lane_valid=16'hFFFF, ptr=9, clear=1 with in_valid=1 -> next cycle lane_valid=0, ptr=0, no write, data retained.
REQ-036 Async reset: assert rst_n=0 between edges while in_valid=1 -> outputs zero immediately, no write on release edge without new stimulus.
REQ-037 Stray ack: out_ack=16'hFFFF on empty block -> lane_valid stays 0, no data change.
